// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  // Narrower frames leave no room for a distinct first and last bit.
  localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit position counter for one serial frame; last flags the final bit position.
module piso_serializer_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_r;

  // Clear has priority over increment; the controller clears on the last bit, so no wrap is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign last = (cnt_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with per-frame bit order, bit strobe,
// valid/ready load handshake and a one-frame holding register for gap-free streaming.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lsb_first,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < MIN_WIDTH) begin : g_width_check
    $error("piso_serializer: WIDTH must be >= 2");
  end

  piso_state_e      state_r;
  piso_state_e      next_state_s;
  logic [WIDTH-1:0] hold_data_r;
  logic             hold_lsb_r;
  logic             hold_full_r;
  logic [WIDTH-1:0] sh_data_r;
  logic             sh_lsb_r;
  logic [CNT_W-1:0] bit_cnt_s;
  logic             bit_last_s;
  logic             accept_s;
  logic             transfer_s;
  logic             shift_s;
  logic             cnt_clear_s;

  assign accept_s = load_valid & load_ready;

  piso_serializer_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (reset),
    .clear (cnt_clear_s),
    .inc   (shift_s),
    .cnt   (bit_cnt_s),
    .last  (bit_last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and per-cycle datapath controls; a held frame reloads on the last bit so no gap appears.
  always_comb begin
    next_state_s = state_r;
    transfer_s   = 1'b0;
    shift_s      = 1'b0;
    cnt_clear_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hold_full_r) begin
          transfer_s   = 1'b1;
          cnt_clear_s  = 1'b1;
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!shift_en) begin
          next_state_s = ST_SHIFT;
        end else if (!bit_last_s) begin
          shift_s      = 1'b1;
          next_state_s = ST_SHIFT;
        end else if (hold_full_r) begin
          transfer_s   = 1'b1;
          cnt_clear_s  = 1'b1;
          next_state_s = ST_SHIFT;
        end else begin
          cnt_clear_s  = 1'b1;
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        cnt_clear_s  = 1'b1;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Holding register: accept and transfer are mutually exclusive because load_ready is low while full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data_r <= {WIDTH{1'b0}};
      hold_lsb_r  <= 1'b0;
      hold_full_r <= 1'b0;
    end else if (accept_s) begin
      hold_data_r <= data_in;
      hold_lsb_r  <= lsb_first;
      hold_full_r <= 1'b1;
    end else if (transfer_s) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  // Shift register: the outgoing bit is always at the end selected by sh_lsb_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_data_r <= {WIDTH{1'b0}};
      sh_lsb_r  <= 1'b0;
    end else if (transfer_s) begin
      sh_data_r <= hold_data_r;
      sh_lsb_r  <= hold_lsb_r;
    end else if (shift_s) begin
      if (sh_lsb_r) begin
        sh_data_r <= {1'b0, sh_data_r[WIDTH-1:1]};
      end else begin
        sh_data_r <= {sh_data_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      sh_data_r <= sh_data_r;
    end
  end

  assign load_ready   = reset & ~hold_full_r;
  assign serial_valid = (state_r == ST_SHIFT);
  assign serial_out   = serial_valid & (sh_lsb_r ? sh_data_r[0] : sh_data_r[WIDTH-1]);
  assign frame_start  = serial_valid & (bit_cnt_s == {CNT_W{1'b0}});
  assign frame_end    = serial_valid & bit_last_s;
  assign busy         = serial_valid | hold_full_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer at WIDTH=4 and WIDTH=8.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic       se4, lv4, rdy4, lsb4, so4, sv4, fs4, fe4, busy4;
  logic [3:0] din4;
  logic       se8, lv8, rdy8, lsb8, so8, sv8, fs8, fe8, busy8;
  logic [7:0] din8;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .shift_en(se4), .load_valid(lv4), .load_ready(rdy4),
    .data_in(din4), .lsb_first(lsb4), .serial_out(so4), .serial_valid(sv4),
    .frame_start(fs4), .frame_end(fe4), .busy(busy4)
  );

  piso_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .shift_en(se8), .load_valid(lv8), .load_ready(rdy8),
    .data_in(din8), .lsb_first(lsb8), .serial_out(so8), .serial_valid(sv8),
    .frame_start(fs8), .frame_end(fe8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one WIDTH=4 frame and check its emission; emit holds bits in emission order (MSB = first out).
  task automatic frame4(input logic [3:0] data, input logic lsb, input logic [3:0] emit, input string tag);
    lv4 = 1'b1; din4 = data; lsb4 = lsb;
    tick();
    lv4 = 1'b0;
    chk({tag, "_lat_sv"}, sv4, 1'b0);
    chk({tag, "_lat_busy"}, busy4, 1'b1);
    chk({tag, "_lat_rdy"}, rdy4, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_so%0d", tag, i), so4, emit[3-i]);
      chk($sformatf("%s_sv%0d", tag, i), sv4, 1'b1);
      chk($sformatf("%s_fs%0d", tag, i), fs4, (i == 0));
      chk($sformatf("%s_fe%0d", tag, i), fe4, (i == 3));
      tick();
    end
    chk({tag, "_end_sv"}, sv4, 1'b0);
    chk({tag, "_end_busy"}, busy4, 1'b0);
  endtask

  // Two MSB-first frames back to back; junk is offered while the hold register is full and must be ignored.
  task automatic b2b4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] junk, input string tag);
    logic [7:0] exp_bits;
    exp_bits = {a, b};
    lv4 = 1'b1; din4 = a; lsb4 = 1'b0;
    tick();
    din4 = b;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_so%0d", tag, i), so4, exp_bits[7-i]);
      chk($sformatf("%s_sv%0d", tag, i), sv4, 1'b1);
      chk($sformatf("%s_fs%0d", tag, i), fs4, (i == 0 || i == 4));
      chk($sformatf("%s_fe%0d", tag, i), fe4, (i == 3 || i == 7));
      chk($sformatf("%s_rdy%0d", tag, i), rdy4, (i == 0 || i >= 4));
      if (i == 3) lv4 = 1'b0;
      tick();
      if (i == 0) din4 = junk;
    end
    chk({tag, "_end_sv"}, sv4, 1'b0);
    chk({tag, "_end_busy"}, busy4, 1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    reset = 1'b0;
    se4 = 1'b1; lv4 = 1'b1; din4 = 4'b1011; lsb4 = 1'b0;
    se8 = 1'b1; lv8 = 1'b1; din8 = 8'h3C;  lsb8 = 1'b0;

    // Reset held while the producers offer data.
    tick();
    tick();
    chk("rst_rdy4", rdy4, 1'b0);
    chk("rst_sv4", sv4, 1'b0);
    chk("rst_so4", so4, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_rdy8", rdy8, 1'b0);
    chk("rst_sv8", sv8, 1'b0);
    lv4 = 1'b0; lv8 = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_rdy4", rdy4, 1'b1);
    chk("rel_rdy8", rdy8, 1'b1);
    tick();

    // Single frames in both bit orders.
    frame4(4'b1011, 1'b0, 4'b1011, "msb");
    frame4(4'b1011, 1'b1, 4'b1101, "lsb");

    // Back-to-back streaming, then backpressure with a changed data_in.
    b2b4(4'b1011, 4'b1100, 4'b0110, "b2b");
    b2b4(4'b0110, 4'b0011, 4'b1111, "bp");

    // Bit strobe: transfer proceeds without shift_en; each bit holds until its strobe.
    lv8 = 1'b1; din8 = a5; lsb8 = 1'b0; se8 = 1'b0;
    tick();
    lv8 = 1'b0;
    tick();
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("se_so%0d_%0d", b, c), so8, a5[7-b]);
        chk($sformatf("se_sv%0d_%0d", b, c), sv8, 1'b1);
        chk($sformatf("se_fs%0d_%0d", b, c), fs8, (b == 0));
        chk($sformatf("se_fe%0d_%0d", b, c), fe8, (b == 7));
        se8 = (c == 2);
        tick();
      end
    end
    se8 = 1'b1;
    chk("se_end_sv", sv8, 1'b0);
    chk("se_end_busy", busy8, 1'b0);

    // Reset in the middle of 8'hF0 with 8'h0F held.
    lv8 = 1'b1; din8 = 8'hF0;
    tick();
    lv8 = 1'b0;
    tick();
    lv8 = 1'b1; din8 = 8'h0F;
    tick();
    lv8 = 1'b0;
    tick();
    chk("mid_sv", sv8, 1'b1);
    chk("mid_busy", busy8, 1'b1);
    chk("mid_rdy", rdy8, 1'b0);
    chk("mid_so", so8, 1'b1);
    reset = 1'b0;
    #1;
    chk("mr_so", so8, 1'b0);
    chk("mr_sv", sv8, 1'b0);
    chk("mr_fs", fs8, 1'b0);
    chk("mr_fe", fe8, 1'b0);
    chk("mr_busy", busy8, 1'b0);
    chk("mr_rdy", rdy8, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("post_sv%0d", i), sv8, 1'b0);
      chk($sformatf("post_busy%0d", i), busy8, 1'b0);
      chk($sformatf("post_rdy%0d", i), rdy8, 1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
